serial_ripple_subtractor: RTL and testbench

- Bit-serial ripple-borrow subtractor. Computes Diff = A - B - Bin over WIDTH clock cycles, one bit per cycle, LSB first.
- It is the inverse-direction companion of the team's combinational ripple-carry adder and reuses the same A/B/carry-style port set.
- Intended for area-constrained datapaths where a start/done handshake is acceptable in exchange for one full-subtractor cell.

---
 rtl/serial_ripple_subtractor.sv | 113 +++++++++++
 tb/tb_serial_ripple_subtractor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell is reused across WIDTH cycles behind a start/done handshake.
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             d_bit;
    logic             brw_nxt;
    logic [WIDTH-1:0] r_nxt;

    // The full-subtractor cell operates on the current LSBs only
    always_comb begin
        d_bit   = a_q[0] ^ b_q[0] ^ brw_q;
        brw_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
        r_nxt   = {d_bit, r_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    brw_d   = Bin;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                r_d   = r_nxt;
                brw_d = brw_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d  = r_nxt;
                    bout_d  = brw_nxt;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    // Status decoded straight from the state flops, so outputs stay registered
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Bench for serial_ripple_subtractor: cycle-level model check plus directed,
// exhaustive and randomized stimulus.
module tb_serial_ripple_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Bout;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Model: an accepted op finishes WIDTH edges after acceptance; result is plain arithmetic
    int           edge_n = 0;
    int           acc_n = 0;
    bit           in_flight = 1'b0;
    logic [W:0]   m_res = '0;
    logic [W-1:0] m_diff = '0;
    logic         m_bout = 1'b0;
    logic         m_done = 1'b0;
    logic         m_busy = 1'b0;

    always @(posedge clk) begin
        edge_n++;
        m_done = 1'b0;
        if (!rst_n) begin
            in_flight = 1'b0;
            m_diff    = '0;
            m_bout    = 1'b0;
        end else if (in_flight) begin
            if (edge_n == acc_n + W) begin
                {m_bout, m_diff} = m_res;
                m_done    = 1'b1;
                in_flight = 1'b0;
            end
        end else if (start) begin
            in_flight = 1'b1;
            acc_n     = edge_n;
            m_res     = {1'b0, A} - {1'b0, B} - {{W{1'b0}}, Bin};
        end
        m_busy = in_flight;
    end

    always @(negedge clk) begin
        if (chk_en)
            chk("cycle_model", 32'({busy, done, Bout, Diff}),
                32'({m_busy, m_done, m_bout, m_diff}));
    end

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic bin, input logic [W-1:0] ed,
                      input logic eb, input bit mid);
        int lat;
        int busyc;
        int donec;
        lat = 0;
        busyc = 0;
        donec = 0;
        A = a;
        B = b;
        Bin = bin;
        start = 1'b1;
        for (int i = 1; i <= W + 3; i++) begin
            @(negedge clk);
            start = (mid && i == 2);
            A = W'($urandom);
            B = W'($urandom);
            Bin = 1'($urandom);
            if (busy) busyc++;
            if (done) begin
                donec++;
                lat = i;
                chk("op_diff", 32'(Diff), 32'(ed));
                chk("op_bout", 32'(Bout), 32'(eb));
            end
        end
        chk("op_latency", lat, W + 1);
        chk("op_busy_cycles", busyc, W);
        chk("op_done_count", donec, 1);
    endtask

    initial begin
        logic [W:0] e;
        int dcnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("reset_state", 32'({busy, done, Bout, Diff}), 32'h0);

        op(4'b0010, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0);
        op(4'b0001, 4'b0010, 1'b0, 4'b1111, 1'b1, 1'b0);
        op(4'b0101, 4'b0011, 1'b1, 4'b0001, 1'b0, 1'b0);
        op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);
        op(4'b1111, 4'b0001, 1'b0, 4'b1110, 1'b0, 1'b1);

        // Held start: back-to-back ops every WIDTH+1 cycles
        A = 4'b1000;
        B = 4'b0111;
        Bin = 1'b0;
        start = 1'b1;
        dcnt = 0;
        for (int i = 1; i <= 3 * (W + 1); i++) begin
            @(negedge clk);
            chk("held_busy", 32'(busy), 32'(!done));
            chk("held_done", 32'(done), 32'(i % (W + 1) == 0));
            if (done) begin
                dcnt++;
                chk("held_diff", 32'({Bout, Diff}), 32'h01);
            end
        end
        chk("held_done_count", dcnt, 3);
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        // Abort mid-run with reset
        A = 4'b0110;
        B = 4'b0011;
        Bin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_state", 32'({busy, done, Bout, Diff}), 32'h0);
        dcnt = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        op(4'b0110, 4'b0011, 1'b0, 4'b0011, 1'b0, 1'b0);

        for (int k = 0; k < (1 << (2 * W + 1)); k++) begin
            logic [31:0] kv;
            kv = 32'(k);
            e = {1'b0, kv[W-1:0]} - {1'b0, kv[2*W-1:W]}
                - {{W{1'b0}}, kv[2*W]};
            op(kv[W-1:0], kv[2*W-1:W], kv[2*W], e[W-1:0], e[W], 1'b0);
        end

        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            A = W'($urandom);
            B = W'($urandom);
            Bin = 1'($urandom);
            rst_n = ($urandom_range(0, 60) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
